spi_sample_receiver: RTL and testbench
======================================

Name: spi_sample_receiver

Overview:
- Upstream stage of the audio path: SPI slave front end that deserialises 16-bit audio samples and hands them to the signal processor.
- Runs entirely in the `input_clk` domain. SCLK, CS_N and MOSI are treated as asynchronous inputs: they are synchronised and edge-detected, never used as a clock.
- Each completed word is delivered over a valid/ready handshake. Overrun and framing faults are reported as single-cycle pulses.

Parameters:
- DATA_WIDTH, 16: bits per SPI frame and width of `sample_out`.
- SYNC_STAGES, 2: flip-flop depth of each input synchroniser; legal values are 2 or more.
- TIMEOUT_CYCLES, 1024: `input_clk` cycles without an SCLK edge before a partial frame is aborted. Used only when the optional feature is enabled.

Ports:
- input_clk  input  1  system clock; sole clock of the block.
- reset  input  1  asynchronous, active-high reset.
- spi_sclk  input  1  SPI serial clock, asynchronous (mode 0: sample MOSI on rising edge).
- spi_chip_select  input  1  active-low frame enable, asynchronous.
- spi_mosi  input  1  serial data, MSB first, asynchronous.
- sample_out  output  DATA_WIDTH  received sample; stable while `sample_valid` is high.
- sample_valid  output  1  sample available.
- sample_ready  input  1  consumer accepts `sample_out` on a cycle where it and `sample_valid` are both high.
- busy  output  1  high while a frame is in progress (state SHIFT or DONE).
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- frame_error  output  1  one-cycle pulse on a malformed frame.

Behaviour:

Reset:
- All outputs and internal registers are 0, state is IDLE.
- Synchroniser flops reset to the inactive values: SCLK=0, CS_N=1, MOSI=0.
- Reset asserted mid-frame discards the partial frame and any held sample. No pulse is emitted on exit from reset.

Input conditioning:
- Each input passes through SYNC_STAGES flops.
- An SCLK rising edge is detected when the synchronised value is 1 and its delayed copy is 0. Falling edges are not used.
- Required SPI timing: SCLK high and low phases each at least 3 `input_clk` periods; MOSI stable about the rising edge.

State machine:
- IDLE: `bit_cnt`=0. Enter SHIFT when synchronised CS_N is 0.
- SHIFT:
  - On each detected rising edge: shift reg = {shift reg[DATA_WIDTH-2:0], MOSI_sync} and `bit_cnt`++.
  - When `bit_cnt` reaches DATA_WIDTH, the word is complete; go to DONE.
  - CS_N rising with 0 < `bit_cnt` < DATA_WIDTH: `frame_error` pulse, discard, go to IDLE.
  - CS_N rising with `bit_cnt`=0: go to IDLE silently.
- DONE:
  - Wait for CS_N=1, then go to IDLE.
  - Any further SCLK rising edge: `frame_error` pulse (once per frame). Extra bits are ignored and the completed word is still delivered.

Word delivery (the cycle after the word completes):
- If `sample_valid`=0, or `sample_valid`=1 with `sample_ready`=1 in that same cycle: load `sample_out` and set `sample_valid`=1.
- Otherwise: keep the held sample, drop the new word, pulse `overrun`.

Handshake:
- `sample_valid` clears on the cycle after acceptance unless a new word loads in that same cycle, in which case it stays 1 with the new data.
- `sample_out` must not change while `sample_valid`=1 and `sample_ready`=0.

Latency:
- `sample_valid` rises SYNC_STAGES+2 or SYNC_STAGES+3 `input_clk` cycles after the raw 16th SCLK rising edge. The ±1 cycle is synchroniser uncertainty.

Back-to-back frames:
- CS_N may re-assert after being deasserted for at least 3 `input_clk` cycles. No gap is required between words at the handshake.

Optional Feature:
- Macro: SPI_RX_FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter runs in SHIFT and resets on every SCLK edge.
  - On reaching TIMEOUT_CYCLES with `bit_cnt` > 0: `frame_error` pulse, partial frame discarded, state goes to DONE (waits for CS_N high).
  - The counter is held at 0 outside SHIFT.
- Undefined: no counter is built; a stalled partial frame waits indefinitely for more SCLK edges or CS_N deassertion.

Test Plan:
1. Single frame 0xA5C3, `sample_ready` tied 1 -> `sample_out`=0xA5C3 with a 1-cycle `sample_valid` within SYNC_STAGES+3 cycles of the 16th edge; `busy` low after CS_N rises; no pulses.
2. `sample_ready`=0, frames 0x1234 then 0x5678 -> `sample_out` holds 0x1234 with `sample_valid`=1, one `overrun` pulse; raise `sample_ready` -> 0x1234 accepted, `sample_valid` falls, 0x5678 never appears.
3. CS_N deasserted after 9 bits, then a full frame 0x00FF -> one `frame_error` pulse, no `sample_valid` for the partial frame, then 0x00FF delivered correctly.
4. 18 SCLK edges in one frame carrying 0xBEEF plus 2 extra bits -> 0xBEEF delivered, exactly one `frame_error` pulse.
5. Reset asserted after bit 7 of a frame, released, then frame 0x8001 -> all outputs 0 during reset; 0x8001 delivered with no error or overrun.
6. With SPI_RX_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=64: SCLK stalled after 5 bits with CS_N held low -> `frame_error` pulse at 64 idle cycles, no sample; after a CS_N deassert/reassert, frame 0x7FFF delivered.

Source files
------------

// File: rtl/spi_sample_receiver.sv
// rtl/spi_sample_receiver.sv - SPI mode-0 slave that deserialises audio samples onto a valid/ready port.
// Optional stalled-frame timeout: define SPI_RX_FRAME_TIMEOUT_EN.
module spi_sample_receiver #(
  parameter int DATA_WIDTH     = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  input_clk,
  input  logic                  reset,
  input  logic                  spi_sclk,
  input  logic                  spi_chip_select,
  input  logic                  spi_mosi,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  frame_error
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;

  logic [1:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  word_done;
  logic                  extra_err;
  logic                  timeout_hit;

  // Synchronisers reset to the idle bus levels so leaving reset never looks like an edge.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_chip_select};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign busy      = (state != IDLE);

`ifdef SPI_RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;
  logic          sclk_edge;

  assign sclk_edge   = sclk_s ^ sclk_d;
  assign timeout_hit = (state == SHIFT) && !sclk_edge && (bit_cnt != '0) &&
                       (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state != SHIFT || sclk_edge) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TW'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      word_done   <= 1'b0;
      frame_error <= 1'b0;
      extra_err   <= 1'b0;
    end else begin
      word_done   <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt   <= '0;
          extra_err <= 1'b0;
          if (!cs_s) state <= SHIFT;
        end
        SHIFT: begin
          if (cs_s) begin
            if (bit_cnt != '0) frame_error <= 1'b1;
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_s};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              word_done <= 1'b1;
              state     <= DONE;
            end
          end else if (timeout_hit) begin
            // Abandoned partial frame: report once and park until CS_N releases.
            frame_error <= 1'b1;
            extra_err   <= 1'b1;
            bit_cnt     <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (sclk_rise && !extra_err) begin
            frame_error <= 1'b1;
            extra_err   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new word may replace the held one only when the consumer takes it in the same cycle.
  always_ff @(posedge input_clk or posedge reset) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_done) begin
        if (!sample_valid || sample_ready) begin
          sample_out   <= shift_reg;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_sample_receiver.sv
// tb/tb_spi_sample_receiver.sv - self-checking bench for spi_sample_receiver.
module tb_spi_sample_receiver;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic        mosi = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        frame_error;

  spi_sample_receiver #(
    .DATA_WIDTH(16),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .input_clk(clk),
    .reset(rst),
    .spi_sclk(sclk),
    .spi_chip_select(cs),
    .spi_mosi(mosi),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .sample_ready(ready),
    .busy(busy),
    .overrun(overrun),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int valid_cycles = 0;
  int last_rise = 0;
  int valid_rise = -1;
  logic [15:0] acc_q[$];
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [15:0] po = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Event recorder: accepted words, pulse counts, and hold-stability of a stalled sample.
  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid && ready) acc_q.push_back(sample_out);
      if (overrun) ovr_cnt++;
      if (frame_error) fe_cnt++;
      if (sample_valid) valid_cycles++;
      if (sample_valid && !pv) valid_rise = cyc;
      if (pv && !pr) begin
        check("hold_valid", {31'd0, sample_valid}, 32'd1);
        check("hold_data", {16'd0, sample_out}, {16'd0, po});
      end
    end
    pv = rst ? 1'b0 : sample_valid;
    pr = ready;
    po = sample_out;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] bits, input int n, input bit keep_cs);
    cs = 1'b0;
    clk_wait(4);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      clk_wait(4);
      sclk = 1'b1;
      last_rise = cyc;
      clk_wait(4);
      sclk = 1'b0;
    end
    clk_wait(4);
    if (!keep_cs) begin
      cs = 1'b1;
      clk_wait(6);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          nbits;
    int          exp_del;
    int          exp_fe;
  } vec_t;

  vec_t        vt[7];
  logic [31:0] bits;
  logic [15:0] words[3];
  int          q0, f0, o0, v0, k;

  initial begin
    vt[0] = '{16'hA5C3, 16, 1, 0};
    vt[1] = '{16'h1357, 9, 0, 1};
    vt[2] = '{16'h00FF, 16, 1, 0};
    vt[3] = '{16'hBEEF, 18, 1, 1};
    vt[4] = '{16'h0000, 16, 1, 0};
    vt[5] = '{16'hFFFF, 16, 1, 0};
    vt[6] = '{16'h4242, 0, 0, 0};

    clk_wait(3);
    @(negedge clk);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_out", {16'd0, sample_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pulses", {30'd0, overrun, frame_error}, 32'd0);
    clk_wait(1);
    rst = 1'b0;
    clk_wait(4);
    check("post_rst_pulses", fe_cnt + ovr_cnt, 32'd0);

    ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      q0 = acc_q.size(); f0 = fe_cnt; o0 = ovr_cnt; v0 = valid_cycles;
      valid_rise = -1;
      if (vt[i].nbits > 16)
        bits = (32'(vt[i].data) << (vt[i].nbits - 16)) | ($urandom & ((32'd1 << (vt[i].nbits - 16)) - 1));
      else
        bits = 32'(vt[i].data) >> (16 - vt[i].nbits);
      send(bits, vt[i].nbits, 1'b0);
      check($sformatf("v%0d_delivered", i), acc_q.size() - q0, vt[i].exp_del);
      if (vt[i].exp_del != 0 && acc_q.size() > q0)
        check($sformatf("v%0d_word", i), {16'd0, acc_q[$]}, {16'd0, vt[i].data});
      check($sformatf("v%0d_frame_error", i), fe_cnt - f0, vt[i].exp_fe);
      check($sformatf("v%0d_overrun", i), ovr_cnt - o0, 32'd0);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      if (vt[i].nbits >= 16)
        check($sformatf("v%0d_valid_width", i), valid_cycles - v0, 32'd1);
      if (vt[i].nbits == 16)
        check($sformatf("v%0d_latency_ok", i),
              {31'd0, (valid_rise - last_rise >= SS + 2) && (valid_rise - last_rise <= SS + 3)}, 32'd1);
    end

    // Stalled consumer: first word held, second dropped with an overrun.
    ready = 1'b0;
    q0 = acc_q.size(); o0 = ovr_cnt;
    send(32'h1234, 16, 1'b0);
    send(32'h5678, 16, 1'b0);
    check("ovr_valid", {31'd0, sample_valid}, 32'd1);
    check("ovr_held", {16'd0, sample_out}, 32'h1234);
    check("ovr_pulses", ovr_cnt - o0, 32'd1);
    ready = 1'b1;
    clk_wait(3);
    check("ovr_accepted_n", acc_q.size() - q0, 32'd1);
    if (acc_q.size() > q0) check("ovr_accepted", {16'd0, acc_q[q0]}, 32'h1234);
    check("ovr_valid_fall", {31'd0, sample_valid}, 32'd0);
    clk_wait(10);
    check("ovr_no_5678", acc_q.size() - q0, 32'd1);

    // Randomized stalled bursts: model keeps the first word, counts the rest as overruns.
    for (int r = 0; r < 6; r++) begin
      ready = 1'b0;
      k = $urandom_range(1, 3);
      q0 = acc_q.size(); o0 = ovr_cnt; f0 = fe_cnt;
      for (int j = 0; j < k; j++) begin
        words[j] = 16'($urandom);
        send(32'(words[j]), 16, 1'b0);
      end
      check($sformatf("rb%0d_held", r), {16'd0, sample_out}, {16'd0, words[0]});
      check($sformatf("rb%0d_overrun", r), ovr_cnt - o0, k - 1);
      ready = 1'b1;
      clk_wait(4);
      check($sformatf("rb%0d_accepted_n", r), acc_q.size() - q0, 32'd1);
      if (acc_q.size() > q0) check($sformatf("rb%0d_accepted", r), {16'd0, acc_q[q0]}, {16'd0, words[0]});
      check($sformatf("rb%0d_frame_error", r), fe_cnt - f0, 32'd0);
    end

    // Randomized free-flowing frames.
    for (int r = 0; r < 8; r++) begin
      words[0] = 16'($urandom);
      q0 = acc_q.size();
      send(32'(words[0]), 16, 1'b0);
      check($sformatf("rf%0d_n", r), acc_q.size() - q0, 32'd1);
      if (acc_q.size() > q0) check($sformatf("rf%0d_word", r), {16'd0, acc_q[$]}, {16'd0, words[0]});
    end

    // Reset mid-frame with a sample held: both are discarded.
    ready = 1'b0;
    send(32'hC0DE, 16, 1'b0);
    send(32'h55, 7, 1'b1);
    rst = 1'b1;
    clk_wait(2);
    @(negedge clk);
    check("mid_rst_outputs", {13'd0, sample_valid, busy, overrun, frame_error} | 32'(sample_out), 32'd0);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    clk_wait(3);
    rst = 1'b0;
    ready = 1'b1;
    clk_wait(6);
    q0 = acc_q.size(); f0 = fe_cnt; o0 = ovr_cnt;
    send(32'h8001, 16, 1'b0);
    check("rst_frame_n", acc_q.size() - q0, 32'd1);
    if (acc_q.size() > q0) check("rst_frame_word", {16'd0, acc_q[q0]}, 32'h8001);
    check("rst_frame_pulses", (fe_cnt - f0) + (ovr_cnt - o0), 32'd0);

`ifdef SPI_RX_FRAME_TIMEOUT_EN
    q0 = acc_q.size(); f0 = fe_cnt;
    send(32'h15, 5, 1'b1);
    clk_wait(80);
    check("to_frame_error", fe_cnt - f0, 32'd1);
    check("to_no_sample", acc_q.size() - q0, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd1);
    cs = 1'b1;
    clk_wait(6);
    check("to_idle", {31'd0, busy}, 32'd0);
    send(32'h7FFF, 16, 1'b0);
    check("to_next_n", acc_q.size() - q0, 32'd1);
    if (acc_q.size() > q0) check("to_next_word", {16'd0, acc_q[$]}, 32'h7FFF);
    check("to_fe_total", fe_cnt - f0, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
